// File: rtl/pg_domain_sequencer_pkg.sv
// pg_pkg: wake FSM states, off-hold length and width helpers
// shared by the power-gating sequencer, its arbiter and interface.
package pg_pkg;

  typedef enum logic {
    W_IDLE,
    W_SETTLE
  } wake_st_e;

  localparam int OFF_HOLD = 2;

  // bits needed to hold values 0..max_v
  function automatic int cnt_w(input int max_v);
    return (max_v < 2) ? 1 : $clog2(max_v + 1);
  endfunction

  // bits needed to index n items
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pg_domain_sequencer_if.sv
// Sequencer bus: req (+force_on with PG_FORCE_ON_EN) in,
// en/rdy/wake_busy/wake_id out. slave = sequencer side.
interface pg_domain_sequencer_if
  import pg_pkg::*;
#(
  parameter int N_DOM = 4
);
  localparam int IW = idx_w(N_DOM);

  logic [N_DOM-1:0] req;
  logic [N_DOM-1:0] en;
  logic [N_DOM-1:0] rdy;
  logic             wake_busy;
  logic [IW-1:0]    wake_id;

`ifdef PG_FORCE_ON_EN
  logic force_on;

  modport master (
    output req, force_on,
    input  en, rdy, wake_busy, wake_id
  );
  modport slave (
    input  req, force_on,
    output en, rdy, wake_busy, wake_id
  );
`else
  modport master (
    output req,
    input  en, rdy, wake_busy, wake_id
  );
  modport slave (
    input  req,
    output en, rdy, wake_busy, wake_id
  );
`endif

endinterface

// File: rtl/pg_domain_sequencer_rr_arbiter.sv
// pg_rr_arbiter: combinational round-robin pick of the first
// pending bit at or after ptr. In: pend, ptr. Out: vld, idx.
module pg_rr_arbiter
  import pg_pkg::*;
#(
  parameter int N_DOM = 4,
  parameter int IW    = idx_w(N_DOM)
) (
  input  logic [N_DOM-1:0] pend,
  input  logic [IW-1:0]    ptr,
  output logic             vld,
  output logic [IW-1:0]    idx
);

  // scan from farthest to nearest so the nearest set bit wins
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = N_DOM - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % N_DOM;
      if (pend[j]) begin
        vld = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pg_domain_sequencer.sv
// Power-gating sequencer: idle shutdown per domain, serialised wakes.
// Ports: ck, rst (async low), bus (slave). Option: PG_FORCE_ON_EN.
module pg_domain_sequencer
  import pg_pkg::*;
#(
  parameter int N_DOM    = 4,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 8
) (
  input logic                   ck,
  input logic                   rst,
  pg_domain_sequencer_if.slave  bus
);

  localparam int IW = idx_w(N_DOM);
  localparam int CW = cnt_w(IDLE_CYC);
  localparam int SW = cnt_w(WAKE_CYC - 1);
  localparam int HW = cnt_w(OFF_HOLD);

  logic [N_DOM-1:0] req_eff;
  logic [N_DOM-1:0] en;
  logic [N_DOM-1:0] rdy;
  logic [N_DOM-1:0] hold_z;
  logic [N_DOM-1:0] pend;

  wake_st_e      st, st_n;
  logic [SW-1:0] settle, settle_n;
  logic [IW-1:0] wid, wid_n;
  logic [IW-1:0] rr_ptr, rr_n;
  logic          busy, busy_n;
  logic          do_grant, do_done;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;

`ifdef PG_FORCE_ON_EN
  assign req_eff = bus.req | {N_DOM{bus.force_on}};
`else
  assign req_eff = bus.req;
`endif

  assign pend = req_eff & ~en & hold_z;

  pg_rr_arbiter #(
    .N_DOM (N_DOM),
    .IW    (IW)
  ) u_arb (
    .pend (pend),
    .ptr  (rr_ptr),
    .vld  (gnt_vld),
    .idx  (gnt_idx)
  );

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      st     <= W_IDLE;
      settle <= '0;
      wid    <= '0;
      rr_ptr <= '0;
      busy   <= 1'b0;
    end else begin
      st     <= st_n;
      settle <= settle_n;
      wid    <= wid_n;
      rr_ptr <= rr_n;
      busy   <= busy_n;
    end
  end

  always_comb begin
    st_n     = st;
    settle_n = settle;
    wid_n    = wid;
    rr_n     = rr_ptr;
    busy_n   = busy;
    do_grant = 1'b0;
    do_done  = 1'b0;
    unique case (st)
      W_IDLE: begin
        if (gnt_vld) begin
          do_grant = 1'b1;
          st_n     = W_SETTLE;
          settle_n = SW'(WAKE_CYC - 1);
          wid_n    = gnt_idx;
          busy_n   = 1'b1;
        end
      end
      W_SETTLE: begin
        if (settle != '0) begin
          settle_n = settle - SW'(1);
        end else begin
          do_done = 1'b1;
          busy_n  = 1'b0;
          st_n    = W_IDLE;
          rr_n    = (wid == IW'(N_DOM - 1)) ? '0 : wid + IW'(1);
        end
      end
      default: st_n = W_IDLE;
    endcase
  end

  // idle timer only runs while fully on, so a waking domain
  // (en=1, rdy=0) keeps it at zero until rdy rises
  for (genvar i = 0; i < N_DOM; i++) begin : g_dom
    logic          en_q;
    logic          rdy_q;
    logic [CW-1:0] idle_q;
    logic [HW-1:0] hold_q;

    always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
        en_q   <= 1'b1;
        rdy_q  <= 1'b1;
        idle_q <= '0;
        hold_q <= '0;
      end else begin
        if (hold_q != '0) hold_q <= hold_q - HW'(1);
        if (en_q && rdy_q) begin
          if (idle_q == CW'(IDLE_CYC)) begin
            en_q   <= 1'b0;
            rdy_q  <= 1'b0;
            idle_q <= '0;
            hold_q <= HW'(OFF_HOLD);
          end else if (req_eff[i]) begin
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + CW'(1);
          end
        end else begin
          idle_q <= '0;
          if (do_grant && gnt_idx == IW'(i)) en_q <= 1'b1;
          if (do_done && wid == IW'(i)) rdy_q <= 1'b1;
        end
      end
    end

    assign en[i]     = en_q;
    assign rdy[i]    = rdy_q;
    assign hold_z[i] = (hold_q == '0);
  end

  assign bus.en        = en;
  assign bus.rdy       = rdy;
  assign bus.wake_busy = busy;
  assign bus.wake_id   = wid;

endmodule

// File: tb/tb_pg_domain_sequencer.sv
// Random-stimulus bench for pg_domain_sequencer against a
// time-stamp based reference model of shutdown and wake rules.
module tb_pg_domain_sequencer;
  import pg_pkg::*;

  localparam int N    = 4;
  localparam int IDLE = 16;
  localparam int WAKE = 8;

  logic ck  = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  pg_domain_sequencer_if #(.N_DOM(N)) bus ();

  pg_domain_sequencer #(
    .N_DOM    (N),
    .IDLE_CYC (IDLE),
    .WAKE_CYC (WAKE)
  ) dut (
    .ck  (ck),
    .rst (rst),
    .bus (bus)
  );

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: per-domain on/ready flags, low-run length,
  // edge of last shutdown, and the single waker with its grant edge
  bit m_en  [N];
  bit m_rdy [N];
  int low   [N];
  int off_at[N];
  int waker, g_at, rr, last_id, t;

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i]   = 1'b1;
      m_rdy[i]  = 1'b1;
      low[i]    = 0;
      off_at[i] = -100;
    end
    waker   = -1;
    g_at    = 0;
    rr      = 0;
    last_id = 0;
    t       = 0;
  endtask

  task automatic m_step(input logic [N-1:0] r);
    bit pend[N];
    t++;
    for (int i = 0; i < N; i++)
      pend[i] = r[i] && !m_en[i] && (t - 1 >= off_at[i] + 2);
    for (int i = 0; i < N; i++) begin
      if (m_en[i] && m_rdy[i]) begin
        if (low[i] == IDLE) begin
          m_en[i]   = 1'b0;
          m_rdy[i]  = 1'b0;
          low[i]    = 0;
          off_at[i] = t;
        end else begin
          low[i] = r[i] ? 0 : low[i] + 1;
        end
      end else begin
        low[i] = 0;
      end
    end
    if (waker >= 0) begin
      if (t == g_at + WAKE) begin
        m_rdy[waker] = 1'b1;
        rr           = (waker + 1) % N;
        waker        = -1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (rr + k) % N;
        if (pend[j] && waker < 0) begin
          waker    = j;
          g_at     = t;
          m_en[j]  = 1'b1;
          last_id  = j;
        end
      end
    end
  endtask

  function automatic logic [N-1:0] vec_en();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_en[i];
    return v;
  endfunction

  function automatic logic [N-1:0] vec_rdy();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_rdy[i];
    return v;
  endfunction

  logic force_v = 1'b0;

  function automatic logic [N-1:0] cur_req();
    return bus.req | {N{force_v}};
  endfunction

  task automatic check_all();
    chk("en", bus.en, vec_en());
    chk("rdy", bus.rdy, vec_rdy());
    chk("wake_busy", bus.wake_busy, (waker >= 0));
    if (waker >= 0) chk("wake_id", bus.wake_id, last_id);
  endtask

  // called at a negedge with inputs already set
  task automatic cycle();
    logic [N-1:0] r;
    r = cur_req();
    @(posedge ck);
    if (rst) m_step(r);
    #1;
    check_all();
    @(negedge ck);
  endtask

  task automatic do_reset(input int len);
    rst = 1'b0;
    #1;
    m_reset();
    chk("rst_en", bus.en, 4'hF);
    chk("rst_rdy", bus.rdy, 4'hF);
    chk("rst_busy", bus.wake_busy, 1'b0);
    @(negedge ck);
    repeat (len) cycle();
    rst = 1'b1;
  endtask

`ifdef PG_FORCE_ON_EN
  assign bus.force_on = force_v;
`endif

  initial begin
    bus.req = '0;
    m_reset();
    @(negedge ck);
    do_reset(2);
    chk("rst_id", bus.wake_id, 0);

    // idle-run from reset: all fall on the 17th edge
    repeat (16) cycle();
    chk("pre_fall_en", bus.en, 4'hF);
    cycle();
    chk("fall17_en", bus.en, 4'h0);
    chk("fall17_rdy", bus.rdy, 4'h0);

    // all request together: grants 0,1,2,3 each WAKE+1 apart
    bus.req = 4'hF;
    repeat (3) cycle();
    chk("first_gnt", bus.en, 4'h1);
    repeat (45) cycle();
    chk("all_on", bus.rdy, 4'hF);

    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 29) == 0) bus.req[i] = ~bus.req[i];
`ifdef PG_FORCE_ON_EN
      if ($urandom_range(0, 199) == 0) force_v = ~force_v;
`endif
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 3));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
